// File: rtl/tug_press_arbiter.sv
// -----------------------------------------------------------------------------
// tug_press_arbiter
//
// Turns the two players' button levels into single press events, queues up to
// MAX_PEND presses per player and issues them one at a time as rope-move
// requests over a valid/ready handshake. Simultaneous demand is granted
// round-robin.
//
// Optional build macro:
//   TUG_CANCEL_EN  when defined, a left and a right press that are both pending
//                  cancel each other instead of producing two moves.
//
// Parameters:
//   MAX_PEND    per-player pending-press capacity (1..7)
//   CNT_W       pending counter width, 2**CNT_W > MAX_PEND
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   in_l, in_r  left / right button levels, synchronous to clk
//   move_ready  rope-position unit accepts the offered move
//   move_valid  a move is offered (registered)
//   move_dir    1 = pull left, 0 = pull right (registered, valid with move_valid)
//   drop_l/_r   one-cycle pulse: a press was lost because its queue was full
//   busy        offer outstanding or any press still queued (combinational)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tug_press_arbiter #(
    parameter int MAX_PEND = 3,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic in_l,
    input  logic in_r,
    input  logic move_ready,
    output logic move_valid,
    output logic move_dir,
    output logic drop_l,
    output logic drop_r,
    output logic busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_PEND);

    state_t           state, state_nxt;
    logic             prev_l, prev_r;
    logic             press_l, press_r;
    logic [CNT_W-1:0] cnt_l, cnt_r;
    logic [CNT_W-1:0] cnt_l_nxt, cnt_r_nxt;
    logic             dec_l, dec_r;
    logic             lose_l, lose_r;
    logic             dir_nxt;
    logic             last_left, last_left_nxt;   // 1 = last grant went left
    logic             choose;

    // Rising-edge detect on the current input against last cycle's level.
    assign press_l = in_l & ~prev_l;
    assign press_r = in_r & ~prev_r;

    // The state register itself drives move_valid, so the output is a flop.
    assign move_valid = (state == OFFER);

    // A new grant is decided when nothing is offered, or when the current
    // offer is being accepted this cycle (back-to-back throughput).
    assign choose = (state == IDLE) | (move_valid & move_ready);

    assign busy = (state == OFFER) | (cnt_l != '0) | (cnt_r != '0);

    // -------------------------------------------------------------------------
    // Next-state / grant logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt     = state;
        dir_nxt       = move_dir;
        last_left_nxt = last_left;
        dec_l         = 1'b0;
        dec_r         = 1'b0;

        if (choose) begin
            if ((cnt_l != '0) && (cnt_r != '0)) begin
`ifdef TUG_CANCEL_EN
                // Opposing presses annihilate; the rope does not move.
                dec_l     = 1'b1;
                dec_r     = 1'b1;
                state_nxt = IDLE;
`else
                state_nxt = OFFER;
                if (last_left) begin
                    dec_r         = 1'b1;
                    dir_nxt       = 1'b0;
                    last_left_nxt = 1'b0;
                end else begin
                    dec_l         = 1'b1;
                    dir_nxt       = 1'b1;
                    last_left_nxt = 1'b1;
                end
`endif
            end else if (cnt_l != '0) begin
                state_nxt     = OFFER;
                dec_l         = 1'b1;
                dir_nxt       = 1'b1;
                last_left_nxt = 1'b1;
            end else if (cnt_r != '0) begin
                state_nxt     = OFFER;
                dec_r         = 1'b1;
                dir_nxt       = 1'b0;
                last_left_nxt = 1'b0;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pending counters: a press into a full queue is lost only if the same
    // cycle does not also grant from that queue.
    // -------------------------------------------------------------------------
    always_comb begin
        lose_l    = press_l & (cnt_l == FULL) & ~dec_l;
        lose_r    = press_r & (cnt_r == FULL) & ~dec_r;
        cnt_l_nxt = cnt_l + CNT_W'(press_l & ~lose_l) - CNT_W'(dec_l);
        cnt_r_nxt = cnt_r + CNT_W'(press_r & ~lose_r) - CNT_W'(dec_r);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: asynchronous reset so move_valid drops the instant reset rises,
    // discarding any offer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            move_dir  <= 1'b0;
            last_left <= 1'b0;
            prev_l    <= 1'b0;
            prev_r    <= 1'b0;
            cnt_l     <= '0;
            cnt_r     <= '0;
            drop_l    <= 1'b0;
            drop_r    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational blocks.
            state     <= state_nxt;
            move_dir  <= dir_nxt;
            last_left <= last_left_nxt;
            prev_l    <= in_l;
            prev_r    <= in_r;
            cnt_l     <= cnt_l_nxt;
            cnt_r     <= cnt_r_nxt;
            drop_l    <= lose_l;
            drop_r    <= lose_r;
        end
    end

endmodule

// File: doc/tug_press_arbiter.md
# tug_press_arbiter

Arbiter and sequencer for the two players' button inputs in the tug-of-war datapath. It converts each held button into single press events and queues up to MAX_PEND presses per player. It then issues them one at a time, as rope-move requests, over a valid/ready handshake to the rope-position unit. Ties are resolved round-robin. An optional mode cancels opposing presses against each other.

## Interface
- MAX_PEND, 3: per-player pending-press capacity, 1..7.
- CNT_W, 3: width of the pending counters; must satisfy 2^CNT_W > MAX_PEND.

- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_l  in  1  left player button level, synchronous to clk.
- in_r  in  1  right player button level, synchronous to clk.
- move_ready  in  1  rope-position unit accepts the current move.
- move_valid  out  1  move request pending; registered.
- move_dir  out  1  1 = pull left, 0 = pull right; registered; meaningful only while move_valid.
- drop_l  out  1  one-cycle pulse: a left press was lost because cnt_l was full.
- drop_r  out  1  one-cycle pulse: a right press was lost because cnt_r was full.
- busy  out  1  combinational; high while in OFFER or while cnt_l or cnt_r is non-zero.

## Operation
- Edge filter per side:
  - press_x = in_x & ~prev_x, evaluated combinationally on current inputs.
  - prev_x <= in_x every cycle; prev_x resets to 0.
  - A button held through reset release therefore yields exactly one press.
  - A button held for N cycles yields one press.
- Pending counters cnt_l and cnt_r, range 0..MAX_PEND:
  - Each cycle: next = cnt + inc - dec.
  - inc = press_x, except when cnt == MAX_PEND and dec == 0. In that case the press is lost: the counter is unchanged and drop_x is registered high for one cycle.
  - A simultaneous inc and dec leaves the count unchanged.
- FSM states are IDLE and OFFER. "Choose" is evaluated in IDLE, and in OFFER on the handshake cycle (move_valid & move_ready).
  - If neither count is non-zero: go to (or stay in) IDLE.
  - If exactly one count is non-zero: go to OFFER with that side; register move_dir; decrement that counter in the same cycle.
  - If both counts are non-zero: grant the side opposite last_grant; update last_grant. last_grant resets to right, so left wins the first tie.
  - Counts used by Choose are the registered values, before this cycle's press increments.
- In OFFER without a handshake: hold move_valid = 1 and move_dir stable. There is no withdrawal.
- Outputs at reset: move_valid = 0, move_dir = 0, drop_l = 0, drop_r = 0, busy = 0. State is IDLE, counters are 0, last_grant is right.
- Reset mid-offer: move_valid falls asynchronously and the pending move is discarded. The downstream unit must not count a handshake on the cycle reset is asserted.

## Timing
- Latency: in_l rises before edge k, so cnt_l = 1 after edge k. move_valid = 1 with move_dir = 1 after edge k+1.
- Throughput: one move per cycle when move_ready is held high and presses are queued. Back-to-back offers go through the handshake path of Choose.
- drop_x is asserted in the cycle after the edge at which the press was lost.

## Configuration
- TUG_CANCEL_EN defined:
  - In Choose, when both counts are non-zero, decrement both and go to/stay in IDLE. No move is issued and last_grant is unchanged.
  - Equal pulls therefore cancel.
- TUG_CANCEL_EN undefined: round-robin behaviour as described in Operation.

## Test plan
- Reset release with in_l held high: cnt_l becomes 1. move_valid = 1 and move_dir = 1 one cycle later. Holding in_l for 10 cycles produces no second move.
- move_ready = 0; pulse in_r 5 times, 2 cycles apart: the first press enters OFFER and the counter holds 3. The 5th press gives drop_r = 1 for one cycle. Then move_ready = 1 gives 4 right moves (dir = 0) on consecutive cycles, after which busy = 0.
- Both buttons rise on the same edge with move_ready = 1, macro undefined: moves are L then R on consecutive cycles. A second simultaneous press gives L then R again.
- Same stimulus with TUG_CANCEL_EN defined: no move_valid ever asserts, both counts return to 0, and busy falls after 2 cycles.
- Assert reset while move_valid = 1 and move_ready = 0: move_valid = 0 immediately, all counters are 0, and no move appears after release without a new press.
- Left press and a left grant on the same edge with cnt_l = MAX_PEND: the count is unchanged and no drop_l pulse occurs.
